// File: rtl/amo_unit_pkg.sv
// Shared A-extension definitions for the AMO controller: op codes, FSM states
// and the load/store-stage <-> AMO unit interface structs.
package amo_unit_pkg;

  localparam int XLEN = 32;

  // Encodings 12..15 are not listed and fall through as NONE.
  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_XOR  = 4'd5,
    AMO_AND  = 4'd6,
    AMO_OR   = 4'd7,
    AMO_MIN  = 4'd8,
    AMO_MAX  = 4'd9,
    AMO_MINU = 4'd10,
    AMO_MAXU = 4'd11
  } type_amo_ops_e;

  typedef enum logic [1:0] {
    AMO_IDLE = 2'd0,
    AMO_LD   = 2'd1,
    AMO_ST   = 2'd2,
    AMO_DONE = 2'd3
  } type_amo_states_e;

  typedef struct packed {
    type_amo_ops_e amo_ops;
    logic          is_amo;
    logic          amo_flush;
    logic          ack;
  } type_lsu2amo_ctrl_s;

  typedef struct packed {
    logic [XLEN-1:0] lsu_addr;
    logic [XLEN-1:0] rs2_operand;
    logic [XLEN-1:0] r_data;
  } type_lsu2amo_data_s;

  typedef struct packed {
    logic ld_req;
    logic st_req;
    logic rd_wr_req;
    logic amo_done;
  } type_amo2lsu_ctrl_s;

  typedef struct packed {
    logic [XLEN-1:0] w_data;
    logic [XLEN-1:0] amo_wrb_data;
  } type_amo2lsu_data_s;

  // True for the read-modify-write ops (SWAP through MAXU).
  function automatic logic is_rmw(type_amo_ops_e op);
    return (op >= AMO_SWAP) && (op <= AMO_MAXU);
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic: combines the loaded word with rs2.
// Ties in MIN/MAX keep the loaded value.
module amo_alu
  import amo_unit_pkg::*;
(
  input  logic [XLEN-1:0] ld_q,
  input  logic [XLEN-1:0] rs2_operand,
  input  type_amo_ops_e   amo_ops,
  output logic [XLEN-1:0] result
);

  // Select the new memory value for the current op.
  always_comb begin
    result = ld_q;
    case (amo_ops)
      AMO_SWAP: result = rs2_operand;
      AMO_ADD:  result = ld_q + rs2_operand;
      AMO_XOR:  result = ld_q ^ rs2_operand;
      AMO_AND:  result = ld_q & rs2_operand;
      AMO_OR:   result = ld_q | rs2_operand;
      AMO_MIN:  result = ($signed(rs2_operand) < $signed(ld_q)) ? rs2_operand : ld_q;
      AMO_MAX:  result = ($signed(rs2_operand) > $signed(ld_q)) ? rs2_operand : ld_q;
      AMO_MINU: result = (rs2_operand < ld_q) ? rs2_operand : ld_q;
      AMO_MAXU: result = (rs2_operand > ld_q) ? rs2_operand : ld_q;
      default:  result = ld_q;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// AMO / LR / SC sequencer beside the load/store stage. Runs each request as a
// read-modify-write over the data bus and owns the LR/SC reservation.
//
//   state | meaning
//   IDLE  | waiting for is_amo; failed SC goes straight to DONE
//   LD    | ld_req held until ack; loaded word captured in ld_q
//   ST    | st_req held until ack; w_data is rs2 (SC) or the ALU result
//   DONE  | one-cycle amo_done / rd_wr_req with the writeback value
//
// Op code and operands are expected to stay stable while a request is active.
module amo_unit
  import amo_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  type_lsu2amo_ctrl_s lsu2amo_ctrl_i,
  input  type_lsu2amo_data_s lsu2amo_data_i,
  output type_amo2lsu_ctrl_s amo2lsu_ctrl_o,
  output type_amo2lsu_data_s amo2lsu_data_o
);

  type_amo_states_e state_q;
  logic [XLEN-1:0]  ld_q;
  logic [XLEN-1:0]  wrb_q;
  logic             res_valid_q;
  logic [XLEN-3:0]  res_addr_q;
  logic [XLEN-1:0]  alu_result;
  logic             unused_addr_lsb;

  type_amo_ops_e    op;
  logic             flush;
  logic             ack;
  logic             res_hit;

  assign op      = lsu2amo_ctrl_i.amo_ops;
  assign flush   = lsu2amo_ctrl_i.amo_flush;
  assign ack     = lsu2amo_ctrl_i.ack;
  assign res_hit = res_valid_q && (res_addr_q == lsu2amo_data_i.lsu_addr[XLEN-1:2]);

  // Reservation is word granular, so the byte offset is not needed here.
  assign unused_addr_lsb = ^lsu2amo_data_i.lsu_addr[1:0];

  amo_alu u_amo_alu (
    .ld_q        (ld_q),
    .rs2_operand (lsu2amo_data_i.rs2_operand),
    .amo_ops     (op),
    .result      (alu_result)
  );

  // Sequencer state, load capture, writeback value and reservation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= AMO_IDLE;
      ld_q        <= '0;
      wrb_q       <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else if (flush) begin
      state_q <= AMO_IDLE;
    end else begin
      case (state_q)
        AMO_IDLE: begin
          if (lsu2amo_ctrl_i.is_amo) begin
            if (op == AMO_LR || is_rmw(op)) begin
              state_q <= AMO_LD;
            end else if (op == AMO_SC) begin
              if (res_hit) begin
                state_q <= AMO_ST;
              end else begin
                wrb_q       <= {{(XLEN-1){1'b0}}, 1'b1};
                res_valid_q <= 1'b0;
                state_q     <= AMO_DONE;
              end
            end
          end
        end
        AMO_LD: begin
          if (ack) begin
            ld_q <= lsu2amo_data_i.r_data;
            if (op == AMO_LR) begin
              res_valid_q <= 1'b1;
              res_addr_q  <= lsu2amo_data_i.lsu_addr[XLEN-1:2];
              wrb_q       <= lsu2amo_data_i.r_data;
              state_q     <= AMO_DONE;
            end else begin
              state_q <= AMO_ST;
            end
          end
        end
        AMO_ST: begin
          if (ack) begin
            if (op == AMO_SC) begin
              wrb_q       <= '0;
              res_valid_q <= 1'b0;
            end else begin
              wrb_q <= ld_q;
            end
            state_q <= AMO_DONE;
          end
        end
        default: state_q <= AMO_IDLE;
      endcase
    end
  end

  // Moore request decode, with flush killing every request in the same cycle.
  always_comb begin
    amo2lsu_ctrl_o = '0;
    amo2lsu_data_o = '0;
    case (state_q)
      AMO_LD: amo2lsu_ctrl_o.ld_req = !flush;
      AMO_ST: begin
        amo2lsu_ctrl_o.st_req = !flush;
        amo2lsu_data_o.w_data = (op == AMO_SC) ? lsu2amo_data_i.rs2_operand : alu_result;
      end
      AMO_DONE: begin
        amo2lsu_ctrl_o.rd_wr_req   = !flush;
        amo2lsu_ctrl_o.amo_done    = !flush;
        amo2lsu_data_o.amo_wrb_data = wrb_q;
      end
      default: ;
    endcase
  end

endmodule
